btb_updater: RTL and testbench

BTB_UPDATER -- requirements
Module: btb_updater

---
 rtl/btb_updater_pkg.sv | 20 ++
 rtl/btb_updater_if.sv | 31 +++
 rtl/btb_update_fifo.sv | 67 ++++++
 rtl/btb_updater.sv | 90 +++++++++
 tb/tb_btb_updater.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_updater_pkg.sv
// Shared types for the BTB update queue: FSM states and the queued branch entry.
package btb_updater_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/btb_updater_if.sv
// Resolved-branch update port and BTB write port of the BTB updater.
interface btb_updater_if #(
  parameter int unsigned DEPTH = 4
);
  import btb_updater_pkg::*;

  localparam int unsigned CW = count_width(DEPTH);

  logic            update_valid;
  logic            update_taken;
  logic [XLEN-1:0] update_pc;
  logic [XLEN-1:0] update_target;
  logic            update_ready;
  logic            flush;
  logic            btb_write;
  logic [XLEN-1:0] btb_address;
  logic [XLEN-1:0] btb_wdata;
  logic            btb_wresp;
  logic [CW-1:0]   pending_count;

  modport master (
    output update_valid, update_taken, update_pc, update_target, flush, btb_wresp,
    input  update_ready, btb_write, btb_address, btb_wdata, pending_count
  );

  modport slave (
    input  update_valid, update_taken, update_pc, update_target, flush, btb_wresp,
    output update_ready, btb_write, btb_address, btb_wdata, pending_count
  );

endinterface

// File: rtl/btb_update_fifo.sv
// Circular update queue with newest-entry target overwrite and flush that can keep the head.
module btb_update_fifo
  import btb_updater_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq,
  input  btb_entry_t      enq_entry,
  input  logic            overwrite,
  input  logic [XLEN-1:0] overwrite_target,
  input  logic            deq,
  input  logic            flush,
  input  logic            keep_head,
  output btb_entry_t      head_entry,
  output logic [XLEN-1:0] tail_pc,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  btb_entry_t      mem [DEPTH];
  logic [AW-1:0]   head_q, tail_q, newest, tail_f, tail_d, head_d;
  logic [CW-1:0]   count_q, count_f, count_d;

  // Flush is applied first so a same-cycle enqueue lands behind whatever survives it.
  always_comb begin
    newest  = tail_q - AW'(1);
    tail_f  = tail_q;
    count_f = count_q;
    if (flush) begin
      tail_f  = keep_head ? head_q + AW'(1) : head_q;
      count_f = keep_head ? CW'(1) : '0;
    end
    tail_d  = enq ? tail_f + AW'(1) : tail_f;
    head_d  = deq ? head_q + AW'(1) : head_q;
    count_d = count_f + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail_f] <= enq_entry;
    end
    if (overwrite) begin
      mem[newest].target <= overwrite_target;
    end
  end

  assign head_entry = mem[head_q];
  assign tail_pc    = mem[newest].pc;
  assign count      = count_q;

endmodule

// File: rtl/btb_updater.sv
// Queues taken-branch updates (coalescing repeats of the newest PC) and drains them to the BTB.
module btb_updater
  import btb_updater_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  btb_updater_if.slave  bus
);

  localparam int unsigned CW = count_width(DEPTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   count;
  btb_entry_t      head_entry, enq_entry;
  logic [XLEN-1:0] tail_pc;
  logic [XLEN-1:0] addr_q, wdata_q, load_target;
  logic            ready, accept, newest_in_flight, coalesce, enq, deq, load;

  assign ready            = (count < CW'(DEPTH));
  assign accept           = bus.update_valid & bus.update_taken & ready;
  assign newest_in_flight = (state_q == WRITE) && (count == CW'(1));
  // After a flush the newest entry is either gone or in flight, so flush never coalesces.
  assign coalesce         = accept & ~bus.flush & (count != '0) &
                            (tail_pc == bus.update_pc) & ~newest_in_flight;
  assign enq              = accept & ~coalesce;
  assign deq              = (state_q == WRITE) & bus.btb_wresp;
  assign enq_entry        = '{pc: bus.update_pc, target: bus.update_target};

  btb_update_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk              (clk),
    .rst              (rst),
    .enq              (enq),
    .enq_entry        (enq_entry),
    .overwrite        (coalesce),
    .overwrite_target (bus.update_target),
    .deq              (deq),
    .flush            (bus.flush),
    .keep_head        (state_q == WRITE),
    .head_entry       (head_entry),
    .tail_pc          (tail_pc),
    .count            (count)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0 && !bus.flush) begin
          state_d = WRITE;
          load    = 1'b1;
        end
      end
      WRITE: begin
        if (bus.btb_wresp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A coalesce into a lone head on the launch cycle must reach the write, not just the queue.
  assign load_target = (coalesce && count == CW'(1)) ? bus.update_target : head_entry.target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        addr_q  <= head_entry.pc;
        wdata_q <= load_target;
      end
    end
  end

  assign bus.update_ready  = ready;
  assign bus.btb_write     = (state_q == WRITE);
  assign bus.btb_address   = addr_q;
  assign bus.btb_wdata     = wdata_q;
  assign bus.pending_count = count;

endmodule

// File: tb/tb_btb_updater.sv
// Bench for btb_updater: queue-level reference model checked every cycle, plus directed literal checks.
module tb_btb_updater;
  import btb_updater_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  btb_updater_if #(.DEPTH(DEPTH)) bus ();

  btb_updater #(
    .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending updates as a plain queue; busy means q[0] is being written.
  btb_entry_t m_q[$];
  bit         m_busy = 1'b0;

  initial begin
    forever begin : model_step
      int unsigned n;
      bit          acc, go, done;
      btb_entry_t  e;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_busy = 1'b0;
      end else begin
        n    = m_q.size();
        acc  = bus.update_valid && bus.update_taken && (n < DEPTH);
        go   = !m_busy && (n > 0) && !bus.flush;
        done = m_busy && bus.btb_wresp;
        if (bus.flush) begin
          if (m_busy) begin
            while (m_q.size() > 1) void'(m_q.pop_back());
          end else begin
            m_q.delete();
          end
        end
        if (acc) begin
          if (m_q.size() > 0 && m_q[m_q.size()-1].pc == bus.update_pc &&
              !(m_busy && m_q.size() == 1)) begin
            m_q[m_q.size()-1].target = bus.update_target;
          end else begin
            e.pc     = bus.update_pc;
            e.target = bus.update_target;
            m_q.push_back(e);
          end
        end
        if (done) begin
          void'(m_q.pop_front());
          m_busy = 1'b0;
        end
        if (go) m_busy = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_write", 32'(bus.btb_write), 32'(m_busy));
      check("cmp_count", 32'(bus.pending_count), 32'(m_q.size()));
      check("cmp_ready", 32'(bus.update_ready), 32'(m_q.size() < DEPTH));
      if (m_busy && m_q.size() > 0) begin
        check("cmp_address", bus.btb_address, m_q[0].pc);
        check("cmp_wdata", bus.btb_wdata, m_q[0].target);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    bus.update_valid = 1'b0;
    bus.update_taken = 1'b0;
    bus.flush        = 1'b0;
    bus.btb_wresp    = 1'b0;
  endtask

  task automatic set_upd(input logic t, input logic [31:0] pc, input logic [31:0] tgt);
    bus.update_valid  = 1'b1;
    bus.update_taken  = t;
    bus.update_pc     = pc;
    bus.update_target = tgt;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    quiet();
    bus.update_pc     = '0;
    bus.update_target = '0;
    tick();
    check("reset_write", 32'(bus.btb_write), 32'd0);
    check("reset_count", 32'(bus.pending_count), 32'd0);
    check("reset_ready", 32'(bus.update_ready), 32'd1);
    check("reset_address", bus.btb_address, 32'd0);
    check("reset_wdata", bus.btb_wdata, 32'd0);
    tick();
    rst = 1'b0;

    // Single update: write rises two edges after acceptance and holds until wresp.
    set_upd(1'b1, 32'h60, 32'h80);
    tick();
    quiet();
    check("single_count_1", 32'(bus.pending_count), 32'd1);
    check("single_write_early", 32'(bus.btb_write), 32'd0);
    tick();
    check("single_write", 32'(bus.btb_write), 32'd1);
    check("single_address", bus.btb_address, 32'h60);
    check("single_wdata", bus.btb_wdata, 32'h80);
    tick();
    tick();
    check("single_hold", 32'(bus.btb_write), 32'd1);
    check("single_hold_addr", bus.btb_address, 32'h60);
    bus.btb_wresp = 1'b1;
    tick();
    bus.btb_wresp = 1'b0;
    check("single_done_write", 32'(bus.btb_write), 32'd0);
    check("single_done_count", 32'(bus.pending_count), 32'd0);

    // Not-taken updates never queue.
    set_upd(1'b0, 32'h60, 32'h80);
    tick();
    quiet();
    check("nt_count", 32'(bus.pending_count), 32'd0);
    tick();
    check("nt_write", 32'(bus.btb_write), 32'd0);

    // Coalesce two updates to the same PC while another entry is in flight.
    set_upd(1'b1, 32'h10, 32'h20);
    tick();
    quiet();
    tick();
    check("coal_busy", 32'(bus.btb_write), 32'd1);
    set_upd(1'b1, 32'h100, 32'h200);
    tick();
    set_upd(1'b1, 32'h100, 32'h240);
    tick();
    quiet();
    check("coal_count", 32'(bus.pending_count), 32'd2);
    check("coal_first_addr", bus.btb_address, 32'h10);
    bus.btb_wresp = 1'b1;
    tick();
    bus.btb_wresp = 1'b0;
    check("coal_bubble", 32'(bus.btb_write), 32'd0);
    check("coal_count_1", 32'(bus.pending_count), 32'd1);
    tick();
    check("coal_write", 32'(bus.btb_write), 32'd1);
    check("coal_address", bus.btb_address, 32'h100);
    check("coal_wdata", bus.btb_wdata, 32'h240);
    bus.btb_wresp = 1'b1;
    tick();
    bus.btb_wresp = 1'b0;
    tick();
    check("coal_empty", 32'(bus.pending_count), 32'd0);
    check("coal_no_extra", 32'(bus.btb_write), 32'd0);

    // Full queue: fifth distinct update is dropped, writes drain in order.
    for (int unsigned i = 0; i < 5; i++) begin
      set_upd(1'b1, 32'h1000 + 16 * i, 32'h2000 + i);
      tick();
      if (i == 3) check("full_ready", 32'(bus.update_ready), 32'd0);
    end
    quiet();
    check("full_count", 32'(bus.pending_count), 32'd4);
    for (int unsigned i = 0; i < 4; i++) begin
      check("full_write", 32'(bus.btb_write), 32'd1);
      check("full_address", bus.btb_address, 32'h1000 + 16 * i);
      check("full_wdata", bus.btb_wdata, 32'h2000 + i);
      bus.btb_wresp = 1'b1;
      tick();
      bus.btb_wresp = 1'b0;
      tick();
    end
    check("full_drained", 32'(bus.pending_count), 32'd0);
    check("full_idle", 32'(bus.btb_write), 32'd0);

    // Flush with the head in flight keeps only that write.
    for (int unsigned i = 0; i < 3; i++) begin
      set_upd(1'b1, 32'h300 + 16 * i, 32'h400 + i);
      tick();
    end
    quiet();
    check("flush_pre_count", 32'(bus.pending_count), 32'd3);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_count", 32'(bus.pending_count), 32'd1);
    check("flush_write", 32'(bus.btb_write), 32'd1);
    check("flush_address", bus.btb_address, 32'h300);
    bus.btb_wresp = 1'b1;
    tick();
    bus.btb_wresp = 1'b0;
    tick();
    tick();
    check("flush_empty", 32'(bus.pending_count), 32'd0);
    check("flush_no_more", 32'(bus.btb_write), 32'd0);

    // Asynchronous reset in the middle of a write.
    set_upd(1'b1, 32'h500, 32'h600);
    tick();
    quiet();
    tick();
    check("rstw_write", 32'(bus.btb_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstw_write_low", 32'(bus.btb_write), 32'd0);
    check("rstw_count", 32'(bus.pending_count), 32'd0);
    check("rstw_ready", 32'(bus.update_ready), 32'd1);
    check("rstw_address", bus.btb_address, 32'd0);
    check("rstw_wdata", bus.btb_wdata, 32'd0);
    tick();
    rst = 1'b0;
    bus.btb_wresp = 1'b1;
    tick();
    bus.btb_wresp = 1'b0;
    check("rstw_wresp_ignored", 32'(bus.pending_count), 32'd0);
    check("rstw_idle", 32'(bus.btb_write), 32'd0);

    // Random traffic over a small PC set so coalescing, flush and full cases recur.
    for (int unsigned i = 0; i < 3000; i++) begin
      bus.update_valid  = ($urandom_range(0, 9) < 7);
      bus.update_taken  = ($urandom_range(0, 3) != 0);
      bus.update_pc     = 32'h40 + 32'(4 * $urandom_range(0, 3));
      bus.update_target = $urandom;
      bus.flush         = ($urandom_range(0, 24) == 0);
      bus.btb_wresp     = ($urandom_range(0, 9) < 4);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      tick();
    end
    quiet();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
